// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU codes, request kinds and the NOP word shared by the
// decoder control unit and the instruction encoder.
package decode_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef enum logic [2:0] {K_R, K_I, K_LOAD, K_STORE, K_BRANCH} kind_e;
endpackage

// File: rtl/rv32_field_encoder.sv
// rv32_field_encoder: combinational packing of kind/alu/regs/imm into an RV32I
// word; any illegal field yields the NOP with o_err set.
module rv32_field_encoder
   import decode_pkg::*;
(
   input  logic [2:0]  i_kind,
   input  logic [2:0]  i_alu,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [31:0] i_imm,
   output logic [31:0] o_instr,
   output logic        o_err
);
   logic [2:0]  w_f3;
   logic        w_alu_ok, w_imm12_ok, w_bimm_ok, w_ok;
   logic [31:0] w_word;

   // 12-bit immediates need bits [31:11] as a pure sign extension; branch
   // offsets are 13-bit, even.
   assign w_imm12_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);
   assign w_bimm_ok  = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];

   always_comb begin
      w_alu_ok = 1'b1;
      w_f3     = 3'b000;
      case (i_alu)
         ALU_ADD, ALU_SUB: w_f3 = 3'b000;
         ALU_AND:          w_f3 = 3'b111;
         ALU_OR:           w_f3 = 3'b110;
         ALU_SLT:          w_f3 = 3'b010;
         default:          w_alu_ok = 1'b0;
      endcase
      w_ok   = 1'b0;
      w_word = NOP;
      case (kind_e'(i_kind))
         K_R: begin
            w_ok   = w_alu_ok;
            w_word = {(i_alu == ALU_SUB) ? 7'b0100000 : 7'b0000000, i_rs2, i_rs1, w_f3, i_rd, OP_R};
         end
         K_I: begin
            w_ok   = w_alu_ok & (i_alu != ALU_SUB) & w_imm12_ok;
            w_word = {i_imm[11:0], i_rs1, w_f3, i_rd, OP_I};
         end
         K_LOAD: begin
            w_ok   = w_imm12_ok;
            w_word = {i_imm[11:0], i_rs1, 3'b010, i_rd, OP_LOAD};
         end
         K_STORE: begin
            w_ok   = w_imm12_ok;
            w_word = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OP_STORE};
         end
         K_BRANCH: begin
            w_ok   = w_bimm_ok;
            w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b000, i_imm[4:1], i_imm[11], OP_BRANCH};
         end
         default: w_ok = 1'b0;
      endcase
      o_instr = w_ok ? w_word : NOP;
      o_err   = ~w_ok;
   end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: buffered RV32I encoder; 2-entry in-order output FIFO with
// valid/ready on both sides and a saturating illegal-request counter.
module instr_encoder
   import decode_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_kind,
   input  logic [2:0]  in_alu,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err,
   output logic [7:0]  err_count
);
   logic [31:0] w_instr;
   logic        w_err, w_push, w_pop;
   logic [32:0] r_mem [2];
   logic [32:0] r_last;
   logic        r_wp, r_rp;
   logic [1:0]  r_cnt;
   logic [7:0]  r_errs;

   rv32_field_encoder u_enc (
      .i_kind(in_kind), .i_alu(in_alu), .i_rd(in_rd), .i_rs1(in_rs1),
      .i_rs2(in_rs2), .i_imm(in_imm), .o_instr(w_instr), .o_err(w_err)
   );

   assign in_ready  = rst & (r_cnt != 2'(DEPTH));
   assign out_valid = r_cnt != 2'd0;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign err_count = r_errs;
   // When empty the last popped word stays on the outputs.
   assign {out_err, out_instr} = out_valid ? r_mem[r_rp] : r_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_last   <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_cnt    <= 2'd0;
         r_errs   <= 8'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= {w_err, w_instr};
            r_wp        <= ~r_wp;
         end
         if (w_pop) begin
            r_last <= r_mem[r_rp];
            r_rp   <= ~r_rp;
         end
         r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
         if (w_push & w_err & ~(&r_errs)) r_errs <= r_errs + 8'd1;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-computed words for the
// instruction encoder, its FIFO handshakes and its reset behaviour.
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_kind = '0;
   logic [2:0]  in_alu = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic        out_err;
   logic [7:0]  err_count;
   int          n_tests = 0;
   int          n_fail = 0;

   instr_encoder #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] k, input logic [2:0] a, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      in_kind = k; in_alu = a; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic req(input string tag, input logic [2:0] k, input logic [2:0] a,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] exp, input logic exp_err);
      drive(k, a, rd, rs1, rs2, imm);
      step();
      in_valid = 1'b0;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_instr"}, out_instr, exp);
      check({tag, "_err"}, 32'(out_err), 32'(exp_err));
   endtask

   initial begin
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
      step(); step();
      check("rst_instr", out_instr, 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
      check("rst_errcnt", 32'(err_count), 32'd0);
      @(negedge clk) rst = 1'b1;
      #1 check("ready_after_rst", 32'(in_ready), 32'd1);

      req("add",  3'd0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
      req("sub",  3'd0, 3'b001, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0);
      req("lw",   3'd2, 3'b111, 5'd5, 5'd2, 5'd0, 32'd8, 32'h00812283, 1'b0);
      req("sw",   3'd3, 3'b000, 5'd9, 5'd2, 5'd6, -32'sd4, 32'hFE612E23, 1'b0);
      req("beq",  3'd4, 3'b000, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b0);
      req("addi", 3'd1, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
      req("beq_min", 3'd4, 3'b000, 5'd0, 5'd0, 5'd0, -32'sd4096, 32'h80000063, 1'b0);
      check("errcnt0", 32'(err_count), 32'd0);

      req("imm2048", 3'd1, 3'b000, 5'd1, 5'd1, 5'd0, 32'd2048, 32'h00000013, 1'b1);
      req("beq_odd", 3'd4, 3'b000, 5'd0, 5'd1, 5'd2, 32'd7, 32'h00000013, 1'b1);
      req("kind6",   3'd6, 3'b000, 5'd1, 5'd1, 5'd1, 32'd0, 32'h00000013, 1'b1);
      check("errcnt3", 32'(err_count), 32'd3);
      req("isub",    3'd1, 3'b001, 5'd1, 5'd1, 5'd0, 32'd1, 32'h00000013, 1'b1);
      req("alu100",  3'd0, 3'b100, 5'd1, 5'd1, 5'd1, 32'd0, 32'h00000013, 1'b1);
      req("beq4096", 3'd4, 3'b000, 5'd0, 5'd1, 5'd2, 32'd4096, 32'h00000013, 1'b1);
      check("errcnt6", 32'(err_count), 32'd6);

      drive(3'd7, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
      for (int i = 0; i < 260; i++) step();
      in_valid = 1'b0;
      check("errcnt_sat", 32'(err_count), 32'd255);
      step();
      check("drained", 32'(out_valid), 32'd0);

      // Backpressure: A, B accepted, C stalls until a slot frees.
      out_ready = 1'b0;
      drive(3'd0, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0);
      step();
      drive(3'd0, 3'b000, 5'd2, 5'd0, 5'd0, 32'd0);
      step();
      check("bp_ready_full", 32'(in_ready), 32'd0);
      drive(3'd0, 3'b000, 5'd3, 5'd0, 5'd0, 32'd0);
      step();
      check("bp_ready_held", 32'(in_ready), 32'd0);
      check("bp_head_stable", out_instr, 32'h000000B3);
      out_ready = 1'b1;
      step();
      check("bp_ready_back", 32'(in_ready), 32'd1);
      check("bp_second", out_instr, 32'h00000133);
      step();
      in_valid = 1'b0;
      check("bp_third", out_instr, 32'h000001B3);
      check("bp_third_valid", 32'(out_valid), 32'd1);
      step();
      check("bp_empty", 32'(out_valid), 32'd0);
      check("bp_hold_last", out_instr, 32'h000001B3);

      for (int i = 1; i <= 20; i++) begin
         drive(3'd1, 3'b000, 5'(i), 5'd0, 5'd0, 32'(i));
         step();
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_ready", 32'(in_ready), 32'd1);
         check("stream_word", out_instr, (32'(i) << 20) | (32'(i) << 7) | 32'h13);
      end
      in_valid = 1'b0;
      step();
      check("stream_end", 32'(out_valid), 32'd0);

      out_ready = 1'b0;
      drive(3'd0, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0);
      step(); step();
      in_valid = 1'b0;
      check("mid_full", 32'(in_ready), 32'd0);
      check("mid_valid_pre", 32'(out_valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("mid_valid_async", 32'(out_valid), 32'd0);
      check("mid_ready_async", 32'(in_ready), 32'd0);
      @(negedge clk) rst = 1'b1;
      out_ready = 1'b1;
      step();
      check("post_rst_ready", 32'(in_ready), 32'd1);
      check("post_rst_empty", 32'(out_valid), 32'd0);
      check("post_rst_errcnt", 32'(err_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
